// File: rtl/day_calendar_counter.sv
// Calendar state (day-of-week, date, month, 2-digit year) advanced by a midnight tick or edited per field.
// Latency: 1 cycle from edge to output; backpressure: none, every tick/inc is consumed or dropped.
module day_calendar_counter #(
    parameter int unsigned START_DOW   = 5,
    parameter int unsigned START_DATE  = 1,
    parameter int unsigned START_MONTH = 1,
    parameter int unsigned START_YEAR  = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       day_tick,
    input  logic       set_mode,
    input  logic [1:0] field_sel,
    input  logic       inc,
    output logic [3:0] bcd,
    output logic [7:0] date_bcd,
    output logic [7:0] month_bcd,
    output logic [7:0] year_bcd,
    output logic       leap,
    output logic       year_wrap
);

    logic [2:0] dow;
    logic [4:0] date;
    logic [3:0] month;
    logic [6:0] year;

    logic [2:0] dow_nxt;
    logic [3:0] month_nxt;
    logic [6:0] year_nxt;
    logic [4:0] dim;
    logic [4:0] dim_month_edit;
    logic [4:0] dim_year_edit;

    function automatic logic [4:0] days_in(input logic [3:0] m, input logic lp);
        logic [4:0] d;
        case (m)
            4'd2:                    d = lp ? 5'd29 : 5'd28;
            4'd4, 4'd6, 4'd9, 4'd11: d = 5'd30;
            default:                 d = 5'd31;
        endcase
        return d;
    endfunction

    // Repeated subtraction keeps the binary->BCD decode a small comparator chain.
    function automatic logic [7:0] to_bcd(input logic [6:0] v);
        logic [3:0] tens;
        logic [6:0] rem;
        tens = 4'd0;
        rem  = v;
        for (int i = 0; i < 9; i++) begin
            if (rem >= 7'd10) begin
                rem  = rem - 7'd10;
                tens = tens + 4'd1;
            end
        end
        return {tens, rem[3:0]};
    endfunction

    assign leap = (year[1:0] == 2'b00);

    always_comb begin
        dow_nxt        = (dow == 3'd6) ? 3'd0 : dow + 3'd1;
        month_nxt      = (month == 4'd12) ? 4'd1 : month + 4'd1;
        year_nxt       = (year == 7'd99) ? 7'd0 : year + 7'd1;
        dim            = days_in(month, leap);
        dim_month_edit = days_in(month_nxt, leap);
        dim_year_edit  = days_in(month, year_nxt[1:0] == 2'b00);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dow       <= START_DOW[2:0];
            date      <= START_DATE[4:0];
            month     <= START_MONTH[3:0];
            year      <= START_YEAR[6:0];
            year_wrap <= 1'b0;
        end else begin
            year_wrap <= 1'b0;
            if (!set_mode) begin
                if (day_tick) begin
                    dow <= dow_nxt;
                    if (date < dim) begin
                        date <= date + 5'd1;
                    end else begin
                        date  <= 5'd1;
                        month <= month_nxt;
                        if (month == 4'd12) begin
                            year      <= year_nxt;
                            year_wrap <= (year == 7'd99);
                        end
                    end
                end
            end else if (inc) begin
                // Edits never carry; month/year edits clamp the date to the new month length.
                case (field_sel)
                    2'd0: dow <= dow_nxt;
                    2'd1: date <= (date >= dim) ? 5'd1 : date + 5'd1;
                    2'd2: begin
                        month <= month_nxt;
                        if (date > dim_month_edit) date <= dim_month_edit;
                    end
                    default: begin
                        year <= year_nxt;
                        if (date > dim_year_edit) date <= dim_year_edit;
                    end
                endcase
            end
        end
    end

    assign bcd       = {1'b0, dow};
    assign date_bcd  = to_bcd({2'b00, date});
    assign month_bcd = to_bcd({3'b000, month});
    assign year_bcd  = to_bcd(year);

endmodule

// File: tb/tb_day_calendar_counter.sv
// Bench for day_calendar_counter: vector table, directed calendar corner sequences, random run vs. a calendar model.
module tb_day_calendar_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       day_tick = 1'b0;
    logic       set_mode = 1'b0;
    logic [1:0] field_sel = 2'd0;
    logic       inc = 1'b0;
    logic [3:0] bcd;
    logic [7:0] date_bcd, month_bcd, year_bcd;
    logic       leap, year_wrap;

    int vectors = 0;
    int miscompares = 0;

    // Calendar model: plain integers for weekday, day, month, year.
    int m_dow, m_d, m_m, m_y;
    bit m_wrap;

    day_calendar_counter dut (
        .clk(clk), .rst(rst), .day_tick(day_tick), .set_mode(set_mode),
        .field_sel(field_sel), .inc(inc), .bcd(bcd), .date_bcd(date_bcd),
        .month_bcd(month_bcd), .year_bcd(year_bcd), .leap(leap), .year_wrap(year_wrap)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       r, t, sm;
        logic [1:0] fs;
        logic       in;
        logic [3:0] e_bcd;
        logic [7:0] e_date, e_month, e_year;
        logic       e_leap, e_wrap;
    } vec_t;

    vec_t tbl[14];

    function automatic int mdays(input int m, input int y);
        if (m == 2) return (y % 4 == 0) ? 29 : 28;
        if (m == 4 || m == 6 || m == 9 || m == 11) return 30;
        return 31;
    endfunction

    function automatic logic [7:0] bcd8(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic model_apply(input bit r, input bit t, input bit sm, input int fs, input bit in);
        if (r) begin
            m_dow = 5; m_d = 1; m_m = 1; m_y = 0; m_wrap = 0;
            return;
        end
        m_wrap = 0;
        if (!sm) begin
            if (t) begin
                m_dow = (m_dow + 1) % 7;
                m_d++;
                if (m_d > mdays(m_m, m_y)) begin
                    m_d = 1;
                    m_m++;
                    if (m_m > 12) begin
                        m_m = 1;
                        m_y++;
                        if (m_y > 99) begin m_y = 0; m_wrap = 1; end
                    end
                end
            end
        end else if (in) begin
            case (fs)
                0: m_dow = (m_dow + 1) % 7;
                1: m_d = m_d % mdays(m_m, m_y) + 1;
                2: m_m = m_m % 12 + 1;
                default: m_y = (m_y + 1) % 100;
            endcase
            if (m_d > mdays(m_m, m_y)) m_d = mdays(m_m, m_y);
        end
    endtask

    task automatic cyc(input bit r, input bit t, input bit sm, input int fs, input bit in);
        rst = r; day_tick = t; set_mode = sm; field_sel = 2'(fs); inc = in;
        model_apply(r, t, sm, fs, in);
        @(posedge clk);
        #1;
    endtask

    task automatic check_vals(input string name, input logic [29:0] exp_v);
        logic [29:0] got;
        got = {bcd, date_bcd, month_bcd, year_bcd, leap, year_wrap};
        vectors++;
        if (got !== exp_v) begin
            miscompares++;
            $display("FAIL %s: got dow=%0h date=%h month=%h year=%h leap=%b wrap=%b, want dow=%0h date=%h month=%h year=%h leap=%b wrap=%b",
                     name, got[29:26], got[25:18], got[17:10], got[9:2], got[1], got[0],
                     exp_v[29:26], exp_v[25:18], exp_v[17:10], exp_v[9:2], exp_v[1], exp_v[0]);
        end
    endtask

    task automatic check_exp(input string name, input logic [3:0] d, input logic [7:0] dt,
                             input logic [7:0] mo, input logic [7:0] yr, input logic lp, input logic w);
        check_vals(name, {d, dt, mo, yr, lp, w});
    endtask

    task automatic check_model(input string name);
        check_vals(name, {4'(m_dow), bcd8(m_d), bcd8(m_m), bcd8(m_y), (m_y % 4 == 0), m_wrap});
    endtask

    task automatic repeat_cyc(input int n, input bit t, input bit sm, input int fs, input bit in);
        for (int i = 0; i < n; i++) cyc(1'b0, t, sm, fs, in);
    endtask

    initial begin
        //          r     t     sm    fs    in    dow   date   month  year   leap  wrap
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 4'd5, 8'h01, 8'h01, 8'h00, 1'b1, 1'b0};
        tbl[1]  = '{1'b0, 1'b0, 1'b1, 2'd3, 1'b1, 4'd5, 8'h01, 8'h01, 8'h01, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 1'b0, 1'b1, 2'd2, 1'b1, 4'd5, 8'h01, 8'h02, 8'h01, 1'b0, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 4'd6, 8'h01, 8'h02, 8'h01, 1'b0, 1'b0};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 2'd0, 1'b1, 4'd0, 8'h01, 8'h02, 8'h01, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b1, 1'b1, 2'd1, 1'b0, 4'd0, 8'h01, 8'h02, 8'h01, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 2'd0, 1'b0, 4'd1, 8'h02, 8'h02, 8'h01, 1'b0, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 2'd1, 1'b1, 4'd2, 8'h03, 8'h02, 8'h01, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b1, 1'b1, 2'd0, 1'b0, 4'd2, 8'h03, 8'h02, 8'h01, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 2'd1, 1'b1, 4'd2, 8'h04, 8'h02, 8'h01, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 2'd3, 1'b1, 4'd2, 8'h04, 8'h02, 8'h02, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 2'd3, 1'b1, 4'd2, 8'h04, 8'h02, 8'h03, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 1'b0, 2'd0, 1'b1, 4'd2, 8'h04, 8'h02, 8'h03, 1'b0, 1'b0};
        tbl[13] = '{1'b1, 1'b0, 1'b1, 2'd2, 1'b1, 4'd5, 8'h01, 8'h01, 8'h00, 1'b1, 1'b0};

        for (int i = 0; i < 14; i++) begin
            cyc(tbl[i].r, tbl[i].t, tbl[i].sm, int'(tbl[i].fs), tbl[i].in);
            check_exp($sformatf("table[%0d]", i), tbl[i].e_bcd, tbl[i].e_date,
                      tbl[i].e_month, tbl[i].e_year, tbl[i].e_leap, tbl[i].e_wrap);
        end

        // Leap-year February rollover into March
        cyc(1'b1, 1'b0, 1'b0, 0, 1'b0);
        check_exp("reset_state", 4'd5, 8'h01, 8'h01, 8'h00, 1'b1, 1'b0);
        repeat_cyc(59, 1'b1, 1'b0, 0, 1'b0);
        check_exp("feb29_leap", 4'd1, 8'h29, 8'h02, 8'h00, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 0, 1'b0);
        check_exp("mar01_after_leap", 4'd2, 8'h01, 8'h03, 8'h00, 1'b1, 1'b0);

        // Non-leap Feb 28 rollover after edits
        cyc(1'b1, 1'b0, 1'b0, 0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 3, 1'b1);
        check_exp("edit_year01", 4'd5, 8'h01, 8'h01, 8'h01, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 2, 1'b1);
        repeat_cyc(27, 1'b0, 1'b1, 1, 1'b1);
        check_exp("edit_feb28", 4'd5, 8'h28, 8'h02, 8'h01, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0, 0, 1'b0);
        check_exp("feb28_rollover", 4'd6, 8'h01, 8'h03, 8'h01, 1'b0, 1'b0);

        // Date clamping on month and year edits
        cyc(1'b1, 1'b0, 1'b0, 0, 1'b0);
        repeat_cyc(30, 1'b0, 1'b1, 1, 1'b1);
        check_exp("edit_jan31", 4'd5, 8'h31, 8'h01, 8'h00, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1, 1'b1);
        check_exp("date_wrap_edit", 4'd5, 8'h01, 8'h01, 8'h00, 1'b1, 1'b0);
        repeat_cyc(30, 1'b0, 1'b1, 1, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 2, 1'b1);
        check_exp("clamp_month_29", 4'd5, 8'h29, 8'h02, 8'h00, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 3, 1'b1);
        check_exp("clamp_year_28", 4'd5, 8'h28, 8'h02, 8'h01, 1'b0, 1'b0);

        // Century wrap: 31/12/99 -> 01/01/00 with one-cycle year_wrap
        cyc(1'b1, 1'b0, 1'b0, 0, 1'b0);
        repeat_cyc(11, 1'b0, 1'b1, 2, 1'b1);
        repeat_cyc(30, 1'b0, 1'b1, 1, 1'b1);
        repeat_cyc(99, 1'b0, 1'b1, 3, 1'b1);
        check_exp("edit_311299", 4'd5, 8'h31, 8'h12, 8'h99, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 3, 1'b1);
        check_exp("year_edit_no_wrap", 4'd5, 8'h31, 8'h12, 8'h00, 1'b1, 1'b0);
        repeat_cyc(99, 1'b0, 1'b1, 3, 1'b1);
        cyc(1'b0, 1'b1, 1'b0, 0, 1'b0);
        check_exp("century_wrap", 4'd6, 8'h01, 8'h01, 8'h00, 1'b1, 1'b1);
        cyc(1'b0, 1'b0, 1'b0, 0, 1'b0);
        check_exp("wrap_one_cycle", 4'd6, 8'h01, 8'h01, 8'h00, 1'b1, 1'b0);

        // Set mode drops ticks; dow wraps 6->0; reset mid-edit
        repeat_cyc(10, 1'b1, 1'b1, 0, 1'b0);
        check_exp("ticks_dropped", 4'd6, 8'h01, 8'h01, 8'h00, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 0, 1'b1);
        check_exp("dow_wrap", 4'd0, 8'h01, 8'h01, 8'h00, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 2, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, 1, 1'b1);
        check_exp("reset_in_edit", 4'd5, 8'h01, 8'h01, 8'h00, 1'b1, 1'b0);

        // Random run against the calendar model
        begin
            bit sm_r;
            sm_r = 1'b0;
            for (int i = 0; i < 4000; i++) begin
                if ($urandom_range(0, 24) == 0) sm_r = ~sm_r;
                cyc(($urandom_range(0, 499) == 0), 1'($urandom_range(0, 1)), sm_r,
                    int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
                check_model($sformatf("random[%0d]", i));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/day_calendar_counter.md
Name: day_calendar_counter

Overview:
- Calendar state keeper that sits directly upstream of the three-digit day-name display decoder.
- Tracks day-of-week, date, month and two-digit year.
- Advances once per midnight pulse from the time-of-day counter.
- Drives the 4-bit day index consumed by the display decoder (0=Mon … 6=Sun), plus BCD date/month/year for the numeric digit displays.
- Provides a set mode so the user can edit each field with a pushbutton pulse.

Parameters:
- START_DOW, 5: day index loaded at reset (0=Mon … 6=Sun); 5 = Saturday, matching 01/01/2000.
- START_DATE, 1: date loaded at reset (1..31; must be valid for START_MONTH/START_YEAR).
- START_MONTH, 1: month loaded at reset (1..12).
- START_YEAR, 0: two-digit year loaded at reset (0..99, interpreted as 2000+year).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- day_tick  in  1  one-cycle pulse at midnight rollover.
- set_mode  in  1  level; high = edit mode.
- field_sel  in  2  edit target: 0 day-of-week, 1 date, 2 month, 3 year.
- inc  in  1  one-cycle pulse (already debounced/edge-detected); increments the selected field.
- bcd  out  4  day index 0..6 to the day-name decoder.
- date_bcd  out  8  date, two BCD digits (tens in [7:4]).
- month_bcd  out  8  month, two BCD digits.
- year_bcd  out  8  year, two BCD digits.
- leap  out  1  high when the current year is a leap year.
- year_wrap  out  1  one-cycle pulse when the year advances 99->00 through day_tick.

Behaviour:
- Reset (rst high at an edge) has priority over everything. State after reset:
  - bcd=START_DOW, date=START_DATE, month=START_MONTH, year=START_YEAR, year_wrap=0.
  - Reset mid-edit discards the edit.
- Outputs are registered state or pure combinational decode of registered state (binary->BCD). Update is visible the cycle after the triggering edge, with no further latency.
- leap = (year mod 4 == 0); year 00 (2000) is a leap year.
- dim (days in month):
  - 31 for months 1,3,5,7,8,10,12.
  - 30 for months 4,6,9,11.
  - 29 for month 2 when leap, otherwise 28.
- Normal mode (set_mode low); inc is ignored:
  - On day_tick: dow <= (dow==6) ? 0 : dow+1.
  - If date < dim: date+1.
  - Otherwise date <= 1 and month advances.
  - Month advance: month 12 -> 1 and year advances; otherwise month+1.
  - Year advance: 99 -> 0 with year_wrap=1 for exactly that one cycle; otherwise year+1.
- Set mode (set_mode high):
  - day_tick is ignored and dropped, not queued.
  - inc advances only the field named by field_sel, sampled in the same cycle as inc:
    - dow: 6 -> 0.
    - date: dim -> 1.
    - month: 12 -> 1.
    - year: 99 -> 0, with no year_wrap.
  - Month or year edits never carry into other fields.
  - After a month or year edit, if date > new dim, date clamps to the new dim in that same update.
  - dow is independent: it is never recomputed from the date.
- Simultaneous events:
  - day_tick with inc in normal mode: the tick is applied, inc is ignored.
  - set_mode transitions have no side effect. A day_tick in the same cycle that set_mode rises is ignored; one in the cycle set_mode falls is applied.
- Invariants:
  - bcd is never outside 0..6.
  - date is always 1..dim.
  - month is always 1..12.
  - Out-of-range parameters are illegal; no behaviour is defined for them.

Test Plan:
1. Reset only -> bcd=5, date_bcd=8'h01, month_bcd=8'h01, year_bcd=8'h00, leap=1, year_wrap=0.
2. From reset, 59 day_tick pulses -> date_bcd=8'h29, month_bcd=8'h02, bcd=1 (Tue). One more tick -> date_bcd=8'h01, month_bcd=8'h03, bcd=2.
3. set_mode=1:
   - field 3 inc x1 -> year 01, leap=0.
   - field 2 inc x1 -> month 02.
   - field 1 inc x27 -> date 28.
   - set_mode=0, one tick -> date_bcd=8'h01, month_bcd=8'h03.
4. From reset, set_mode=1:
   - field 1 inc x30 -> date 31 in month 01.
   - field 2 inc x1 -> month_bcd=8'h02, date_bcd=8'h29 (clamped, leap year).
   - field 3 inc x1 -> year 01, date_bcd=8'h28.
5. Edit to 31/12/99, set_mode=0, one tick -> date_bcd=8'h01, month_bcd=8'h01, year_bcd=8'h00, leap=1, year_wrap high for exactly one cycle.
6. set_mode=1:
   - 10 day_tick pulses -> no field changes.
   - field 0 inc with bcd=6 -> bcd=0.
   - Assert rst on a later cycle while still in set mode -> all fields return to start values next cycle.
